// File: rtl/registers_mp.sv
// Multi-port register file with write bypass and a per-register
// pending scoreboard used to stall decode on outstanding loads.
module registers_mp #(
    parameter int AddressBitWidth = 5,
    parameter int DataBitWidth    = 32,
    parameter int ReadPorts       = 2,
    parameter int WritePorts      = 2,
    parameter bit BypassEnable    = 1'b1,
    parameter bit ZeroRegister    = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ReadPorts*AddressBitWidth-1:0]  rs,
    output logic [ReadPorts*DataBitWidth-1:0]     rs_data_out,
    output logic [ReadPorts-1:0]                  rs_busy_out,
    input  logic [WritePorts*AddressBitWidth-1:0] rd,
    input  logic [WritePorts-1:0]                 rd_write_enable,
    input  logic [WritePorts*DataBitWidth-1:0]    rd_data_in,
    input  logic                                  busy_set,
    input  logic [AddressBitWidth-1:0]            busy_set_rd
);

    localparam int AW      = AddressBitWidth;
    localparam int DW      = DataBitWidth;
    localparam int NumRegs = 1 << AW;

    logic [DW-1:0]         data [NumRegs];
    logic [NumRegs-1:0]    pending;
    logic [WritePorts-1:0] wr_ok;
    logic                  set_ok;
    logic [NumRegs-1:0]    clr_mask;
    logic [NumRegs-1:0]    set_mask;
    logic [AW-1:0]         idx;
    logic [DW-1:0]         val;
    logic                  busy;

    // Qualify write and busy strobes; index 0 is inert when hardwired.
    always_comb begin
        wr_ok  = rd_write_enable;
        set_ok = busy_set;
        for (int w = 0; w < WritePorts; w++) begin
            if (ZeroRegister && rd[w*AW +: AW] == '0) begin
                wr_ok[w] = 1'b0;
            end
        end
        if (ZeroRegister && busy_set_rd == '0) begin
            set_ok = 1'b0;
        end
    end

    // Register storage; later ports override earlier ones on conflict.
    for (genvar r = 0; r < NumRegs; r++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data[r] <= '0;
            end else begin
                for (int w = 0; w < WritePorts; w++) begin
                    if (wr_ok[w] && rd[w*AW +: AW] == AW'(r)) begin
                        data[r] <= rd_data_in[w*DW +: DW];
                    end
                end
            end
        end
    end

    // Build scoreboard clear (writeback) and set (load issue) masks.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        for (int w = 0; w < WritePorts; w++) begin
            if (wr_ok[w]) begin
                clr_mask[rd[w*AW +: AW]] = 1'b1;
            end
        end
        if (set_ok) begin
            set_mask[busy_set_rd] = 1'b1;
        end
    end

    // Pending bits: a set on the same edge as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    // Combinational read ports with optional same-cycle forwarding.
    always_comb begin
        rs_data_out = '0;
        rs_busy_out = '0;
        idx         = '0;
        val         = '0;
        busy        = 1'b0;
        for (int p = 0; p < ReadPorts; p++) begin
            idx  = rs[p*AW +: AW];
            val  = data[idx];
            busy = pending[idx];
            if (BypassEnable) begin
                for (int w = 0; w < WritePorts; w++) begin
                    if (wr_ok[w] && rd[w*AW +: AW] == idx) begin
                        val  = rd_data_in[w*DW +: DW];
                        busy = 1'b0;
                    end
                end
            end
            if (ZeroRegister && idx == '0) begin
                val  = '0;
                busy = 1'b0;
            end
            if (rst_n) begin
                rs_data_out[p*DW +: DW] = val;
                rs_busy_out[p]          = busy;
            end
        end
    end

endmodule

// File: tb/tb_registers_mp.sv
// Scoreboard bench for registers_mp: one bypassing and one
// non-bypassing instance driven by identical stimulus.
module tb_registers_mp;

    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] data;
        logic        busy;
        string       name;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [9:0]    rs;
    logic [9:0]    rd;
    logic [1:0]    we;
    logic [63:0]   wdata;
    logic          busy_set;
    logic [4:0]    busy_set_rd;
    logic [63:0]   dout_b;
    logic [63:0]   dout_n;
    logic [1:0]    bsy_b;
    logic [1:0]    bsy_n;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    registers_mp #(.BypassEnable(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .rs(rs),
        .rs_data_out(dout_b), .rs_busy_out(bsy_b),
        .rd(rd), .rd_write_enable(we), .rd_data_in(wdata),
        .busy_set(busy_set), .busy_set_rd(busy_set_rd)
    );

    registers_mp #(.BypassEnable(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n), .rs(rs),
        .rs_data_out(dout_n), .rs_busy_out(bsy_n),
        .rd(rd), .rd_write_enable(we), .rd_data_in(wdata),
        .busy_set(busy_set), .busy_set_rd(busy_set_rd)
    );

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] ad;
        logic        ab;
        while (q.size() > 0) begin
            e  = q.pop_front();
            ad = (e.dut == 0) ? dout_b[e.port*DW +: DW]
                              : dout_n[e.port*DW +: DW];
            ab = (e.dut == 0) ? bsy_b[e.port] : bsy_n[e.port];
            checks++;
            if (ad !== e.data || ab !== e.busy) begin
                failures++;
                $display("FAIL %s dut%0d port%0d: got data=%h busy=%b, want data=%h busy=%b",
                         e.name, e.dut, e.port, ad, ab, e.data, e.busy);
            end
        end
    end

    task automatic clear_in();
        we       = '0;
        busy_set = 1'b0;
    endtask

    task automatic set_rs(input int p, input logic [4:0] idx);
        rs[p*AW +: AW] = idx;
    endtask

    task automatic wr(input int w, input logic [4:0] idx, input logic [31:0] v);
        rd[w*AW +: AW]    = idx;
        we[w]             = 1'b1;
        wdata[w*DW +: DW] = v;
    endtask

    task automatic bset(input logic [4:0] idx);
        busy_set    = 1'b1;
        busy_set_rd = idx;
    endtask

    task automatic expect_rd(input int dut, input int p, input logic [31:0] d,
                             input logic b, input string name);
        q.push_back('{dut, p, d, b, name});
    endtask

    task automatic expect_both(input int p, input logic [31:0] d,
                               input logic b, input string name);
        expect_rd(0, p, d, b, name);
        expect_rd(1, p, d, b, name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        rs          = '0;
        rd          = '0;
        wdata       = '0;
        busy_set_rd = '0;
        clear_in();
        set_rs(0, 5'd5);
        set_rs(1, 5'd7);
        expect_both(0, 32'h0, 1'b0, "reset_p0");
        expect_both(1, 32'h0, 1'b0, "reset_p1");
        tick();
        tick();
        rst_n = 1'b1;

        // Write then asynchronous reset mid-cycle.
        wr(0, 5'd5, 32'hDEADBEEF);
        expect_rd(0, 0, 32'hDEADBEEF, 1'b0, "wr_bypass");
        expect_rd(1, 0, 32'h0, 1'b0, "wr_nobypass");
        tick();
        clear_in();
        expect_both(0, 32'hDEADBEEF, 1'b0, "wr_stored");
        tick();
        wr(0, 5'd5, 32'hCAFEF00D);
        #2;
        rst_n = 1'b0;
        expect_both(0, 32'h0, 1'b0, "async_reset");
        tick();
        rst_n = 1'b1;
        clear_in();
        expect_both(0, 32'h0, 1'b0, "after_reset");

        // Same-index write conflict, then distinct indices.
        tick();
        wr(0, 5'd7, 32'h11111111);
        wr(1, 5'd7, 32'h22222222);
        set_rs(0, 5'd7);
        expect_rd(0, 0, 32'h22222222, 1'b0, "conflict_bypass");
        expect_rd(1, 0, 32'h0, 1'b0, "conflict_nobypass");
        tick();
        clear_in();
        expect_both(0, 32'h22222222, 1'b0, "conflict_stored");
        tick();
        wr(0, 5'd3, 32'hA);
        wr(1, 5'd4, 32'hB);
        tick();
        clear_in();
        set_rs(0, 5'd3);
        set_rs(1, 5'd4);
        expect_both(0, 32'hA, 1'b0, "dual_x3");
        expect_both(1, 32'hB, 1'b0, "dual_x4");

        // Bypass versus registered read.
        tick();
        wr(0, 5'd9, 32'h5);
        tick();
        clear_in();
        wr(0, 5'd9, 32'h1234);
        set_rs(0, 5'd9);
        expect_rd(0, 0, 32'h1234, 1'b0, "bypass_new");
        expect_rd(1, 0, 32'h5, 1'b0, "nobypass_old");
        tick();
        clear_in();
        expect_both(0, 32'h1234, 1'b0, "bypass_next");

        // Zero register is inert.
        tick();
        wr(0, 5'd0, 32'hFFFFFFFF);
        bset(5'd0);
        set_rs(0, 5'd0);
        expect_both(0, 32'h0, 1'b0, "zero_same");
        tick();
        clear_in();
        expect_both(0, 32'h0, 1'b0, "zero_after");

        // Scoreboard: set at edge N, write at edge N+3.
        tick();
        bset(5'd12);
        set_rs(0, 5'd12);
        set_rs(1, 5'd12);
        expect_both(0, 32'h0, 1'b0, "busy_before_edge");
        tick();
        clear_in();
        expect_both(0, 32'h0, 1'b1, "busy_n1");
        tick();
        expect_both(1, 32'h0, 1'b1, "busy_n2");
        tick();
        wr(1, 5'd12, 32'h77);
        expect_rd(0, 0, 32'h77, 1'b0, "busy_bypass_clear");
        expect_rd(1, 0, 32'h0, 1'b1, "busy_nobypass_held");
        tick();
        clear_in();
        expect_both(0, 32'h77, 1'b0, "busy_cleared");

        // Set and clear on the same edge: set wins.
        tick();
        bset(5'd12);
        tick();
        clear_in();
        expect_both(0, 32'h77, 1'b1, "repend");
        tick();
        wr(0, 5'd12, 32'h1);
        bset(5'd12);
        expect_rd(0, 0, 32'h1, 1'b0, "collide_bypass");
        expect_rd(1, 0, 32'h77, 1'b1, "collide_nobypass");
        tick();
        clear_in();
        expect_both(0, 32'h1, 1'b1, "collide_set_wins");
        tick();
        wr(1, 5'd12, 32'h2);
        tick();
        clear_in();
        expect_both(1, 32'h2, 1'b0, "final_clear");

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
